// File: rtl/apb_uart_v2_pkg.sv
// Shared types and constants for the APB UART control block.
// The register map, the RX FIFO entry layout and the interrupt bit positions live here.
package apb_uart_v2_pkg;

  localparam logic [31:0] REG_TXDATA = 32'h00;
  localparam logic [31:0] REG_RXDATA = 32'h04;
  localparam logic [31:0] REG_TXCTRL = 32'h08;
  localparam logic [31:0] REG_RXCTRL = 32'h0C;
  localparam logic [31:0] REG_IE     = 32'h10;
  localparam logic [31:0] REG_IP     = 32'h14;
  localparam logic [31:0] REG_DIV    = 32'h18;
  localparam logic [31:0] REG_FRAME  = 32'h1C;
  localparam logic [31:0] REG_STATUS = 32'h20;

  // Bit positions shared by IE and IP
  localparam int unsigned IRQ_TXWM  = 0;
  localparam int unsigned IRQ_RXWM  = 1;
  localparam int unsigned IRQ_RXERR = 2;
  localparam int unsigned IRQ_OVF   = 3;

  localparam int unsigned RX_ENTRY_W = 11;

  typedef enum logic [1:0] {
    ParNone = 2'd0,
    ParEven = 2'd1,
    ParOdd  = 2'd2
  } parity_e;

  typedef struct packed {
    logic       ferr;
    logic       perr;
    logic [8:0] data;
  } rx_entry_t;

  typedef struct packed {
    parity_e    parity;
    logic [3:0] dbits;
  } frame_t;

  // STATUS[3:0], bit 0 is rxovr
  typedef struct packed {
    logic ferr;
    logic perr;
    logic txovf;
    logic rxovr;
  } sticky_t;

endpackage

// File: rtl/apb_uart_fifo_v2.sv
// Synchronous FIFO with occupancy level; a push while full only lands when a pop
// happens in the same cycle.
module apb_uart_fifo_v2 #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned LW = $clog2(DEPTH) + 1,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LW'(DEPTH));
  assign level   = level_q;
  assign dout    = mem[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (do_pop && !do_push) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  // Storage is not reset; the level alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/apb_uart_ctrl_v2.sv
// APB register/control block for the UART: TX/RX FIFOs, frame config, sticky
// error status and a single maskable registered interrupt.
module apb_uart_ctrl_v2
  import apb_uart_v2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned APB_AW = 6,
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              apb_psel,
  input  logic              apb_penable,
  input  logic              apb_pwrite,
  input  logic [APB_AW-1:0] apb_paddr,
  input  logic [31:0]       apb_pwdata,
  output logic [31:0]       apb_prdata,
  output logic              apb_pready,
  output logic              apb_pslverr,
  output logic              tx_valid,
  output logic [8:0]        tx_data,
  input  logic              tx_ready,
  input  logic              rx_valid,
  input  logic [8:0]        rx_data,
  input  logic              rx_perr,
  input  logic              rx_ferr,
  output logic [15:0]       cfg_div,
  output logic              cfg_txen,
  output logic              cfg_rxen,
  output logic              cfg_nstop,
  output logic [3:0]        cfg_dbits,
  output logic [1:0]        cfg_parity,
  output logic              irq
);

  logic          acc, wr, rd, mapped;
  logic [31:0]   addr_b, rdata;
  logic          txen_q, txen_d, nstop_q, nstop_d, rxen_q, rxen_d, irq_q, irq_d;
  logic [LW-1:0] txcnt_q, txcnt_d, rxcnt_q, rxcnt_d;
  logic [3:0]    ie_q, ie_d, ip;
  logic [15:0]   div_q, div_d;
  frame_t        frame_q, frame_d;
  sticky_t       sticky_q, sticky_d, sticky_set, sticky_clr;

  logic          tx_push, tx_pop, tx_full, tx_empty;
  logic [LW-1:0] tx_lvl, rx_lvl;
  logic [8:0]    tx_head, rx_lvl9;
  logic          rx_in, rx_pop, rx_full, rx_empty;
  rx_entry_t     rx_din, rx_head;
  logic          unused_bits;

  assign acc    = apb_psel & apb_penable;
  assign wr     = acc & apb_pwrite;
  assign rd     = acc & ~apb_pwrite;
  assign addr_b = 32'(apb_paddr) & 32'hFFFF_FFFC;

  assign tx_push = wr & (addr_b == REG_TXDATA) & ~tx_full;
  assign tx_pop  = tx_valid & tx_ready;
  assign rx_in   = rx_valid & rxen_q;
  assign rx_pop  = rd & (addr_b == REG_RXDATA) & ~rx_empty;
  assign rx_din  = '{ferr: rx_ferr, perr: rx_perr, data: rx_data};

  apb_uart_fifo_v2 #(
    .WIDTH (9),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (apb_pwdata[8:0]),
    .dout  (tx_head),
    .full  (tx_full),
    .empty (tx_empty),
    .level (tx_lvl)
  );

  apb_uart_fifo_v2 #(
    .WIDTH (RX_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_in),
    .pop   (rx_pop),
    .din   (rx_din),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .level (rx_lvl)
  );

  always_comb begin
    sticky_set       = '0;
    sticky_set.rxovr = rx_in & rx_full & ~rx_pop;
    sticky_set.txovf = wr & (addr_b == REG_TXDATA) & tx_full;
    sticky_set.perr  = rx_in & rx_perr;
    sticky_set.ferr  = rx_in & rx_ferr;
    sticky_clr       = (wr && addr_b == REG_STATUS) ? sticky_t'(apb_pwdata[3:0]) : '0;
  end

  always_comb begin
    ip            = '0;
    ip[IRQ_TXWM]  = tx_lvl < txcnt_q;
    ip[IRQ_RXWM]  = rx_lvl > rxcnt_q;
    ip[IRQ_RXERR] = sticky_q.perr | sticky_q.ferr;
    ip[IRQ_OVF]   = sticky_q.rxovr | sticky_q.txovf;
    irq_d         = |(ip & ie_q);
  end

  always_comb begin
    txen_d   = txen_q;
    nstop_d  = nstop_q;
    txcnt_d  = txcnt_q;
    rxen_d   = rxen_q;
    rxcnt_d  = rxcnt_q;
    ie_d     = ie_q;
    div_d    = div_q;
    frame_d  = frame_q;
    // Set wins over a same-cycle write-1-to-clear
    sticky_d = sticky_t'((sticky_q & ~sticky_clr) | sticky_set);
    if (wr) begin
      case (addr_b)
        REG_TXCTRL: begin
          txen_d  = apb_pwdata[0];
          nstop_d = apb_pwdata[1];
          txcnt_d = apb_pwdata[16 +: LW];
        end
        REG_RXCTRL: begin
          rxen_d  = apb_pwdata[0];
          rxcnt_d = apb_pwdata[16 +: LW];
        end
        REG_IE:  ie_d  = apb_pwdata[3:0];
        REG_DIV: div_d = apb_pwdata[15:0];
        REG_FRAME: begin
          if (apb_pwdata[3:0] >= 4'd5 && apb_pwdata[3:0] <= 4'd9) begin
            frame_d.dbits = apb_pwdata[3:0];
          end
          frame_d.parity = (apb_pwdata[5:4] == 2'd3) ? ParNone : parity_e'(apb_pwdata[5:4]);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      txen_q   <= 1'b0;
      nstop_q  <= 1'b0;
      txcnt_q  <= '0;
      rxen_q   <= 1'b0;
      rxcnt_q  <= '0;
      ie_q     <= '0;
      div_q    <= '0;
      frame_q  <= '{parity: ParNone, dbits: 4'd8};
      sticky_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      txen_q   <= txen_d;
      nstop_q  <= nstop_d;
      txcnt_q  <= txcnt_d;
      rxen_q   <= rxen_d;
      rxcnt_q  <= rxcnt_d;
      ie_q     <= ie_d;
      div_q    <= div_d;
      frame_q  <= frame_d;
      sticky_q <= sticky_d;
      irq_q    <= irq_d;
    end
  end

  assign rx_lvl9 = 9'(rx_lvl);

  always_comb begin
    rdata  = '0;
    mapped = 1'b1;
    case (addr_b)
      REG_TXDATA: rdata[31] = tx_full;
      REG_RXDATA: begin
        if (rx_empty) begin
          rdata[31] = 1'b1;
        end else begin
          rdata[30]  = rx_head.perr;
          rdata[29]  = rx_head.ferr;
          rdata[8:0] = rx_head.data;
        end
      end
      REG_TXCTRL: begin
        rdata[0]        = txen_q;
        rdata[1]        = nstop_q;
        rdata[16 +: LW] = txcnt_q;
      end
      REG_RXCTRL: begin
        rdata[0]        = rxen_q;
        rdata[16 +: LW] = rxcnt_q;
      end
      REG_IE:    rdata[3:0]  = ie_q;
      REG_IP:    rdata[3:0]  = ip;
      REG_DIV:   rdata[15:0] = div_q;
      REG_FRAME: rdata[5:0]  = frame_q;
      REG_STATUS: begin
        rdata[3:0]      = sticky_q;
        rdata[16 +: LW] = tx_lvl;
        rdata[31:24]    = rx_lvl9[7:0];
      end
      default: mapped = 1'b0;
    endcase
  end

  assign apb_prdata  = acc ? rdata : '0;
  assign apb_pready  = 1'b1;
  assign apb_pslverr = acc & ~mapped;

  assign tx_valid   = ~tx_empty & txen_q;
  assign tx_data    = tx_head;
  assign cfg_div    = div_q;
  assign cfg_txen   = txen_q;
  assign cfg_rxen   = rxen_q;
  assign cfg_nstop  = nstop_q;
  assign cfg_dbits  = frame_q.dbits;
  assign cfg_parity = frame_q.parity;
  assign irq        = irq_q;

  assign unused_bits = ^{apb_paddr[1:0], apb_pwdata, rx_lvl9[8]};

endmodule

// File: tb/tb_apb_uart_ctrl_v2.sv
// Self-checking bench for apb_uart_ctrl_v2: TX/RX byte streams are scoreboarded
// through queues, register values are checked against expected constants.
module tb_apb_uart_ctrl_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        apb_psel = 1'b0, apb_penable = 1'b0, apb_pwrite = 1'b0;
  logic [5:0]  apb_paddr = '0;
  logic [31:0] apb_pwdata = '0;
  logic [31:0] apb_prdata;
  logic        apb_pready, apb_pslverr;
  logic        tx_valid;
  logic [8:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        rx_valid = 1'b0;
  logic [8:0]  rx_data = '0;
  logic        rx_perr = 1'b0, rx_ferr = 1'b0;
  logic [15:0] cfg_div;
  logic        cfg_txen, cfg_rxen, cfg_nstop;
  logic [3:0]  cfg_dbits;
  logic [1:0]  cfg_parity;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0]  tx_exp_q[$];
  logic [31:0] rx_exp_q[$];

  always #5 clk = ~clk;

  apb_uart_ctrl_v2 #(
    .FIFO_DEPTH (8),
    .APB_AW     (6)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_paddr   (apb_paddr),
    .apb_pwdata  (apb_pwdata),
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .apb_pslverr (apb_pslverr),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_perr     (rx_perr),
    .rx_ferr     (rx_ferr),
    .cfg_div     (cfg_div),
    .cfg_txen    (cfg_txen),
    .cfg_rxen    (cfg_rxen),
    .cfg_nstop   (cfg_nstop),
    .cfg_dbits   (cfg_dbits),
    .cfg_parity  (cfg_parity),
    .irq         (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic apb_write(input logic [5:0] addr, input logic [31:0] data);
    apb_psel   = 1'b1;
    apb_pwrite = 1'b1;
    apb_paddr  = addr;
    apb_pwdata = data;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    @(posedge clk); #1;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
  endtask

  task automatic apb_read(input logic [5:0] addr, input bit inject, input logic [8:0] idata,
                          output logic [31:0] data, output logic err);
    apb_psel   = 1'b1;
    apb_pwrite = 1'b0;
    apb_paddr  = addr;
    @(posedge clk); #1;
    apb_penable = 1'b1;
    if (inject) begin
      rx_valid = 1'b1;
      rx_data  = idata;
    end
    #1;
    data = apb_prdata;
    err  = apb_pslverr;
    @(posedge clk); #1;
    apb_psel    = 1'b0;
    apb_penable = 1'b0;
    rx_valid    = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [5:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    logic        e;
    apb_read(addr, 1'b0, 9'h0, d, e);
    check_eq(tag, d, exp);
  endtask

  task automatic rx_read_chk(input string tag);
    logic [31:0] d, exp;
    logic        e;
    exp = (rx_exp_q.size() > 0) ? rx_exp_q.pop_front() : 32'h8000_0000;
    apb_read(6'h04, 1'b0, 9'h0, d, e);
    check_eq(tag, d, exp);
  endtask

  task automatic rx_pulse(input logic [8:0] data, input logic perr, input logic ferr,
                          input bit expect_push);
    rx_valid = 1'b1;
    rx_data  = data;
    rx_perr  = perr;
    rx_ferr  = ferr;
    if (expect_push) rx_exp_q.push_back({1'b0, perr, ferr, 20'h0, data});
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_perr  = 1'b0;
    rx_ferr  = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic        e;
    logic [8:0]  b;
    int          cyc;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset values
    check_eq("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_prdata_idle", apb_prdata, 32'd0);
    check_eq("rst_pslverr_idle", 32'(apb_pslverr), 32'd0);
    check_eq("rst_pready", 32'(apb_pready), 32'd1);
    check_eq("rst_cfg_dbits", 32'(cfg_dbits), 32'd8);
    read_chk("rst_frame", 6'h1C, 32'h0000_0008);
    read_chk("rst_rxdata", 6'h04, 32'h8000_0000);
    apb_read(6'h3C, 1'b0, 9'h0, d, e);
    check_eq("unmapped_pslverr", 32'(e), 32'd1);
    check_eq("unmapped_prdata", d, 32'd0);

    // Frame / divisor configuration
    apb_write(6'h1C, 32'h0000_0034);
    read_chk("frame_bad_dbits_par3", 6'h1C, 32'h0000_0008);
    apb_write(6'h1C, 32'h0000_0029);
    check_eq("cfg_dbits_9", 32'(cfg_dbits), 32'd9);
    check_eq("cfg_parity_odd", 32'(cfg_parity), 32'd2);
    apb_write(6'h18, 32'h0000_1234);
    check_eq("cfg_div", 32'(cfg_div), 32'h1234);
    apb_write(6'h3C, 32'hFFFF_FFFF);
    read_chk("unmapped_write_no_effect", 6'h18, 32'h0000_1234);

    // TX fill to overflow, then drain in order
    apb_write(6'h08, 32'h0000_0001);
    for (int i = 0; i < 9; i++) begin
      b = 9'(i * 37 + 3);
      if (i < 8) tx_exp_q.push_back(b);
      apb_write(6'h00, {23'h0, b});
    end
    read_chk("tx_full_status", 6'h20, 32'h0008_0002);
    read_chk("txdata_full_flag", 6'h00, 32'h8000_0000);
    tx_ready = 1'b1;
    cyc = 0;
    while (tx_exp_q.size() > 0 && cyc < 40) begin
      if (tx_valid) check_eq("tx_byte", 32'(tx_data), 32'(tx_exp_q.pop_front()));
      @(posedge clk); #1;
      cyc++;
    end
    check_eq("tx_drain_left", 32'(tx_exp_q.size()), 32'd0);
    check_eq("tx_valid_after_drain", 32'(tx_valid), 32'd0);
    tx_ready = 1'b0;

    // RX parity error, sticky bit and W1C
    apb_write(6'h20, 32'h0000_000F);
    apb_write(6'h0C, 32'h0000_0001);
    rx_pulse(9'h1A5, 1'b1, 1'b0, 1'b1);
    rx_read_chk("rx_perr_data");
    read_chk("status_perr", 6'h20, 32'h0000_0004);
    apb_write(6'h20, 32'h0000_0004);
    read_chk("status_perr_cleared", 6'h20, 32'h0000_0000);

    // RX full: pop and push in the same cycle, then a dropped byte
    for (int i = 0; i < 8; i++) rx_pulse(9'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    read_chk("rx_full_status", 6'h20, 32'h0800_0000);
    apb_read(6'h04, 1'b1, 9'h1FF, d, e);
    check_eq("rx_pop_with_push", d, rx_exp_q.pop_front());
    rx_exp_q.push_back(32'h0000_01FF);
    read_chk("rx_full_pop_push_status", 6'h20, 32'h0800_0000);
    rx_pulse(9'h0AA, 1'b0, 1'b0, 1'b0);
    read_chk("rx_overrun_status", 6'h20, 32'h0800_0001);
    for (int i = 0; i < 8; i++) rx_read_chk("rx_drain");
    read_chk("rx_empty_after_drain", 6'h04, 32'h8000_0000);
    apb_write(6'h20, 32'h0000_000F);

    // RX watermark interrupt
    apb_write(6'h0C, 32'h0001_0001);
    apb_write(6'h10, 32'h0000_0002);
    rx_pulse(9'h011, 1'b0, 1'b0, 1'b1);
    check_eq("irq_lvl1", 32'(irq), 32'd0);
    rx_pulse(9'h022, 1'b0, 1'b0, 1'b1);
    check_eq("irq_same_cycle", 32'(irq), 32'd0);
    @(posedge clk); #1;
    check_eq("irq_rise", 32'(irq), 32'd1);
    read_chk("ip_rxwm", 6'h14, 32'h0000_0002);
    rx_read_chk("rx_pop_irq");
    check_eq("irq_hold", 32'(irq), 32'd1);
    @(posedge clk); #1;
    check_eq("irq_fall", 32'(irq), 32'd0);

    // Reset with both FIFOs non-empty
    apb_write(6'h00, 32'h0000_0055);
    apb_write(6'h00, 32'h0000_0066);
    check_eq("tx_valid_pre_rst", 32'(tx_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_mid_tx_valid", 32'(tx_valid), 32'd0);
    check_eq("rst_mid_irq", 32'(irq), 32'd0);
    rst = 1'b0;
    rx_exp_q.delete();
    read_chk("rst_mid_status", 6'h20, 32'h0000_0000);
    read_chk("rst_mid_rxdata", 6'h04, 32'h8000_0000);
    read_chk("rst_mid_txctrl", 6'h08, 32'h0000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
